pipelined_fill_memory: RTL

- Backing main-memory model that services the cache fill FSM and the D-cache write path.
- Accepts one request per cycle. A read returns its word exactly LATENCY cycles later with a one-cycle data_valid pulse.
- Word-addressed 16-bit data and 16-bit byte addresses; addr[0] is ignored.
- Sits directly downstream of the fill FSM: consumes memory_address, produces memory_data_valid and fill data.

---
 rtl/mem_pkg.sv | 15 +
 rtl/pipelined_fill_memory_if.sv | 26 ++
 rtl/mem_read_pipe_stage.sv | 29 ++
 rtl/pipelined_fill_memory.sv | 94 +++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and the read-pipeline entry type for the fill memory model.
package mem_pkg;

    localparam int MEM_DATA_WIDTH         = 16;
    localparam int MEM_ADDR_WIDTH         = 16;
    localparam int DEFAULT_LATENCY        = 4;
    localparam int DEFAULT_MEM_WORDS_LOG2 = 15;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic                      valid;
        logic [MEM_DATA_WIDTH-1:0] data;
    } pipe_entry_t;

endpackage

// File: rtl/pipelined_fill_memory_if.sv
// Request/response bundle between the fill FSM / D-cache write path and the memory.
//
// Handshake: there is no ready. Every rising edge that sees enable=1 is an accepted
// request (read when wr=0, write when wr=1). Each accepted read produces exactly one
// data_valid pulse, in issue order; data_out is meaningful only while data_valid=1.
interface pipelined_fill_memory_if
    import mem_pkg::*;
();
    logic                      enable;
    logic                      wr;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] data_in;
    logic [MEM_DATA_WIDTH-1:0] data_out;
    logic                      data_valid;
    logic                      reads_pending;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, reads_pending
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, reads_pending
    );
endinterface

// File: rtl/mem_read_pipe_stage.sv
// Single registered {valid, data} slot of the read-return pipeline.
// The data field only loads on a valid entry, so the last stage naturally holds
// the most recently returned word while bubbles pass through.
module mem_read_pipe_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  pipe_entry_t i_entry,
    output pipe_entry_t o_entry
);

    pipe_entry_t r_entry;

    // Shift valid every cycle; capture data only with a real read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else begin
            r_entry.valid <= i_entry.valid;
            if (i_entry.valid) begin
                r_entry.data <= i_entry.data;
            end
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/pipelined_fill_memory.sv
// Backing main-memory model: one request per cycle, reads return after LATENCY
// cycles through a chain of pipe stages. Read data is sampled from the array at
// issue, so later writes never affect reads already in flight.
// LATENCY must lie in 1..8.
module pipelined_fill_memory
    import mem_pkg::*;
#(
    parameter int LATENCY        = DEFAULT_LATENCY,
    parameter int MEM_WORDS_LOG2 = DEFAULT_MEM_WORDS_LOG2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipelined_fill_memory_if.slave  bus
);

    localparam int DEPTH = 1 << MEM_WORDS_LOG2;

    // Storage is deliberately not reset: contents survive rst_n.
    logic [MEM_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                      r_rst_done;

    logic                      w_accept;
    logic                      w_rd_accept;
    logic                      w_wr_accept;
    logic [MEM_WORDS_LOG2-1:0] w_index;
    logic                      w_pending;
    logic                      w_unused_addr;
    pipe_entry_t               w_stage_in  [LATENCY];
    pipe_entry_t               w_stage_out [LATENCY];

    // Word index; addr[0] and bits above the array depth are dropped, so high
    // addresses alias modulo the array size.
    assign w_index = bus.addr[MEM_WORDS_LOG2:1];

    generate
        if (MEM_WORDS_LOG2 < MEM_ADDR_WIDTH - 1) begin : g_addr_hi
            assign w_unused_addr = ^{bus.addr[0], bus.addr[MEM_ADDR_WIDTH-1:MEM_WORDS_LOG2+1]};
        end else begin : g_addr_full
            assign w_unused_addr = bus.addr[0];
        end
    endgenerate

    // Goes high one edge after reset release so a request on the release edge is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    assign w_accept    = bus.enable & r_rst_done;
    assign w_rd_accept = w_accept & ~bus.wr;
    assign w_wr_accept = w_accept &  bus.wr;

    // Array write port; the same-edge read into stage 0 sees the old word.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_index] <= bus.data_in;
        end
    end

    // Stage 0 captures the addressed word on reads; writes and idles insert bubbles.
    generate
        for (genvar g = 0; g < LATENCY; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign w_stage_in[g].valid = w_rd_accept;
                assign w_stage_in[g].data  = r_mem[w_index];
            end else begin : g_body
                assign w_stage_in[g] = w_stage_out[g-1];
            end

            mem_read_pipe_stage u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_entry (w_stage_in[g]),
                .o_entry (w_stage_out[g])
            );
        end
    endgenerate

    // Any read still travelling through the pipe counts as pending.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_pending = w_pending | w_stage_out[i].valid;
        end
    end

    assign bus.data_valid    = w_stage_out[LATENCY-1].valid;
    assign bus.data_out      = w_stage_out[LATENCY-1].data;
    assign bus.reads_pending = w_pending;

endmodule
